// File: rtl/timer_pkg.sv
// Shared definitions for the timer/stopwatch family: FSM encoding, BCD constants and tick rate.
// Also provides a constant-only helper that turns an integer parameter into packed BCD.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] BCD_59            = 8'h59;
  localparam int         TICKS_PER_SEC_DEF = 1000;

  // Used only to elaborate parameters; no division is ever built into the datapath.
  function automatic logic [7:0] to_bcd2(input int v);
    to_bcd2 = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping from MAX_BCD to 00; carry_o flags an increment at MAX_BCD.
// Updates on the clock edge; val_nxt_o exposes the value being loaded so the parent can register it.
module bcd_mod_counter
  import timer_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic       hold_i,
  output logic [7:0] val_nxt_o,
  output logic       carry_o
);

  logic [7:0] val_q;
  logic [7:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 8'h00;
    end else if (inc_i && !hold_i) begin
      if (val_q == MAX_BCD) begin
        val_d = 8'h00;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  // Carry ignores hold so the parent can detect overflow and freeze the chain in the same cycle.
  assign carry_o   = inc_i && (val_q == MAX_BCD);
  assign val_nxt_o = val_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Count-up HH:MM:SS stopwatch with pause, lap freeze, clear and sticky overflow.
// All outputs registered; a second boundary is visible on the same edge the prescaler wraps.
module stopwatch_counter
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int MAX_HOUR      = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_clear,
  output logic [7:0] hour_out_bcd,
  output logic [7:0] minute_out_bcd,
  output logic [7:0] second_out_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int              PW           = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX    = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]      MAX_HOUR_BCD = to_bcd2(MAX_HOUR);

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [23:0]   snap_q, snap_d;
  logic          lap_q, lap_d;
  logic          ovf_q;
  logic          running_q;
  logic [23:0]   disp_q, disp_d;

  logic          ss_ev, lc_ev, tick, cnt_clr;
  logic          sec_carry, min_carry, hour_carry;
  logic [7:0]    sec_nxt, min_nxt, hour_nxt;
  logic [23:0]   count_nxt;

  assign ss_ev     = start_stop;
  assign lc_ev     = lap_clear && !start_stop;
  // The edge that pauses does not advance the prescaler, so no partial second is consumed.
  assign tick      = (state_q == ST_RUN) && !ss_ev && (presc_q == PRESC_MAX);
  assign cnt_clr   = (state_q == ST_PAUSE) && lc_ev;
  assign count_nxt = {hour_nxt, min_nxt, sec_nxt};

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_sec (
    .clk(clk), .rst(rst), .inc_i(tick), .clr_i(cnt_clr), .hold_i(hour_carry),
    .val_nxt_o(sec_nxt), .carry_o(sec_carry)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_min (
    .clk(clk), .rst(rst), .inc_i(sec_carry), .clr_i(cnt_clr), .hold_i(hour_carry),
    .val_nxt_o(min_nxt), .carry_o(min_carry)
  );

  bcd_mod_counter #(.MAX_BCD(MAX_HOUR_BCD)) u_hour (
    .clk(clk), .rst(rst), .inc_i(min_carry), .clr_i(cnt_clr), .hold_i(hour_carry),
    .val_nxt_o(hour_nxt), .carry_o(hour_carry)
  );

  always_comb begin
    lap_d  = lap_q;
    snap_d = snap_q;
    if (cnt_clr) begin
      lap_d  = 1'b0;
      snap_d = 24'h0;
    end else if ((state_q == ST_RUN) && lc_ev) begin
      lap_d = !lap_q;
      if (!lap_q) begin
        snap_d = count_nxt;
      end
    end
    disp_d = lap_d ? snap_d : count_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      snap_q    <= 24'h0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      disp_q    <= 24'h0;
    end else begin
      lap_q  <= lap_d;
      snap_q <= snap_d;
      disp_q <= disp_d;
      case (state_q)
        ST_IDLE: begin
          if (ss_ev) begin
            state_q   <= ST_RUN;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ss_ev) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (tick) begin
            presc_q <= '0;
            if (hour_carry) begin
              ovf_q     <= 1'b1;
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (ss_ev && !ovf_q) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end else if (lc_ev) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign hour_out_bcd   = disp_q[23:16];
  assign minute_out_bcd = disp_q[15:8];
  assign second_out_bcd = disp_q[7:0];
  assign running        = running_q;
  assign lap_active     = lap_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap_clear = 1'b0;
  logic [7:0] hour_out_bcd, minute_out_bcd, second_out_bcd;
  logic       running, lap_active, overflow;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [23:0] hms;
    logic [2:0]  flags;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_counter #(.TICKS_PER_SEC(4), .MAX_HOUR(1)) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .lap_clear(lap_clear),
    .hour_out_bcd(hour_out_bcd),
    .minute_out_bcd(minute_out_bcd),
    .second_out_bcd(second_out_bcd),
    .running(running),
    .lap_active(lap_active),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input logic [23:0] hms, input logic r, input logic l,
                          input logic o, input string nm);
    exp_t e;
    e.cyc   = c;
    e.hms   = hms;
    e.flags = {r, l, o};
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle pulse so that it is sampled by edge number n.
  task automatic pulse_at(input int n, input logic ss, input logic lc);
    while (cyc < n - 1) begin
      @(posedge clk); #1;
    end
    start_stop = ss;
    lap_clear  = lc;
    @(posedge clk); #1;
    start_stop = 1'b0;
    lap_clear  = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compares every entry that falls due, sampling at the falling edge.
  initial begin
    exp_t        e;
    logic [23:0] act;
    logic [2:0]  actf;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e    = exp_q.pop_front();
        act  = {hour_out_bcd, minute_out_bcd, second_out_bcd};
        actf = {running, lap_active, overflow};
        n_tests++;
        if (e.cyc != cyc || act !== e.hms || actf !== e.flags) begin
          n_fail++;
          $display("FAIL %s cyc=%0d due=%0d got hms=%h run/lap/ovf=%b want hms=%h run/lap/ovf=%b",
                   e.name, cyc, e.cyc, act, actf, e.hms, e.flags);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    push_exp(cyc, 24'h000000, 0, 0, 0, "reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: first increment after TICKS_PER_SEC edges, minute carry after 240 cycles
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    push_exp(t0,       24'h000000, 1, 0, 0, "t1_start");
    push_exp(t0 + 3,   24'h000000, 1, 0, 0, "t1_before_tick");
    push_exp(t0 + 4,   24'h000001, 1, 0, 0, "t1_first_tick");
    push_exp(t0 + 239, 24'h000059, 1, 0, 0, "t1_59s");
    push_exp(t0 + 240, 24'h000100, 1, 0, 0, "t1_minute_carry");
    pulse_at(t0 + 242, 1, 0);
    push_exp(t0 + 242, 24'h000100, 0, 0, 0, "t1_pause");
    pulse_at(t0 + 243, 0, 1);
    push_exp(t0 + 243, 24'h000000, 0, 0, 0, "t1_clear");

    // 2: pause keeps the partial second
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    push_exp(t0 + 4, 24'h000001, 1, 0, 0, "t2_1s");
    push_exp(t0 + 8, 24'h000002, 1, 0, 0, "t2_2s");
    pulse_at(t0 + 11, 1, 0);
    push_exp(t0 + 11, 24'h000002, 0, 0, 0, "t2_paused");
    push_exp(t0 + 40, 24'h000002, 0, 0, 0, "t2_hold_mid");
    push_exp(t0 + 60, 24'h000002, 0, 0, 0, "t2_hold_end");
    pulse_at(t0 + 61, 1, 0);
    push_exp(t0 + 61, 24'h000002, 1, 0, 0, "t2_resume");
    push_exp(t0 + 62, 24'h000002, 1, 0, 0, "t2_resume_p1");
    push_exp(t0 + 63, 24'h000003, 1, 0, 0, "t2_resume_tick");
    push_exp(t0 + 67, 24'h000004, 1, 0, 0, "t2_next_tick");
    pulse_at(t0 + 68, 1, 0);
    push_exp(t0 + 68, 24'h000004, 0, 0, 0, "t2_pause2");
    pulse_at(t0 + 69, 0, 1);
    push_exp(t0 + 69, 24'h000000, 0, 0, 0, "t2_clear");

    // 3: lap freeze, release, capture on a tick edge, persistence across pause
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    push_exp(t0 + 20, 24'h000005, 1, 0, 0, "t3_5s");
    pulse_at(t0 + 21, 0, 1);
    push_exp(t0 + 21, 24'h000005, 1, 1, 0, "t3_lap_on");
    push_exp(t0 + 24, 24'h000005, 1, 1, 0, "t3_frozen_6");
    push_exp(t0 + 36, 24'h000005, 1, 1, 0, "t3_frozen_9");
    pulse_at(t0 + 37, 0, 1);
    push_exp(t0 + 37, 24'h000009, 1, 0, 0, "t3_lap_off");
    push_exp(t0 + 40, 24'h000010, 1, 0, 0, "t3_live_10");
    pulse_at(t0 + 44, 0, 1);
    push_exp(t0 + 44, 24'h000011, 1, 1, 0, "t3_lap_on_tick");
    push_exp(t0 + 48, 24'h000011, 1, 1, 0, "t3_frozen_12");
    pulse_at(t0 + 49, 1, 0);
    push_exp(t0 + 49, 24'h000011, 0, 1, 0, "t3_pause_lap");
    pulse_at(t0 + 50, 0, 1);
    push_exp(t0 + 50, 24'h000000, 0, 0, 0, "t3_clear");

    // 5: simultaneous start_stop and lap_clear
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    pulse_at(t0 + 5, 0, 1);
    push_exp(t0 + 5, 24'h000001, 1, 1, 0, "t5_lap_on");
    pulse_at(t0 + 10, 1, 1);
    push_exp(t0 + 10, 24'h000001, 0, 1, 0, "t5_both_in_run");
    push_exp(t0 + 19, 24'h000001, 0, 1, 0, "t5_paused");
    pulse_at(t0 + 20, 1, 1);
    push_exp(t0 + 20, 24'h000001, 1, 1, 0, "t5_both_in_pause");
    pulse_at(t0 + 24, 0, 1);
    push_exp(t0 + 24, 24'h000003, 1, 0, 0, "t5_live_kept");
    pulse_at(t0 + 25, 1, 0);
    pulse_at(t0 + 26, 0, 1);
    push_exp(t0 + 26, 24'h000000, 0, 0, 0, "t5_clear");

    // 6: asynchronous reset mid-run at 00:12:34
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    push_exp(t0 + 3012, 24'h001233, 1, 0, 0, "t6_12m33");
    push_exp(t0 + 3016, 24'h001234, 1, 0, 0, "t6_12m34");
    wait_cyc(t0 + 3017);
    #1;
    rst = 1'b1;
    push_exp(cyc, 24'h000000, 0, 0, 0, "t6_async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    push_exp(t0,     24'h000000, 1, 0, 0, "t6_restart");
    push_exp(t0 + 4, 24'h000001, 1, 0, 0, "t6_restart_tick");
    pulse_at(t0 + 5, 1, 0);
    pulse_at(t0 + 6, 0, 1);
    push_exp(t0 + 6, 24'h000000, 0, 0, 0, "t6_clear");

    // 4: hour carry and overflow with MAX_HOUR=1
    t0 = cyc + 2;
    pulse_at(t0, 1, 0);
    push_exp(t0 + 14396, 24'h005959, 1, 0, 0, "t4_59m59");
    push_exp(t0 + 14400, 24'h010000, 1, 0, 0, "t4_hour_carry");
    push_exp(t0 + 28796, 24'h015959, 1, 0, 0, "t4_max");
    push_exp(t0 + 28800, 24'h015959, 0, 0, 1, "t4_overflow");
    pulse_at(t0 + 28805, 1, 0);
    push_exp(t0 + 28805, 24'h015959, 0, 0, 1, "t4_ss_ignored");
    push_exp(t0 + 28815, 24'h015959, 0, 0, 1, "t4_still_held");
    pulse_at(t0 + 28820, 0, 1);
    push_exp(t0 + 28820, 24'h000000, 0, 0, 0, "t4_ovf_clear");
    pulse_at(t0 + 28825, 1, 0);
    push_exp(t0 + 28825, 24'h000000, 1, 0, 0, "t4_restart");
    push_exp(t0 + 28829, 24'h000001, 1, 0, 0, "t4_restart_tick");

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, need 0", exp_q.size());
      n_fail += exp_q.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Count-up stopwatch, the complement of the countdown timer. Runs from the same 1 kHz system tick and accumulates elapsed HH:MM:SS in packed BCD, in the same output format the display mux already consumes. Supports start/stop, a lap freeze of the display, clear, and overflow detection.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per elapsed second (1 kHz clk); must be >= 2
MAX_HOUR, 99, highest hour value before overflow; 1..99

Ports:
clk  input  1  system clock, 1 kHz
rst  input  1  asynchronous, active-high reset
start_stop  input  1  single-cycle pulse: start/resume or pause
lap_clear  input  1  single-cycle pulse: in RUN toggles lap freeze; in PAUSE clears to zero
hour_out_bcd  output  8  displayed hours, packed BCD [7:4] tens, [3:0] units
minute_out_bcd  output  8  displayed minutes, packed BCD 00..59
second_out_bcd  output  8  displayed seconds, packed BCD 00..59
running  output  1  high in RUN
lap_active  output  1  high while the display is frozen
overflow  output  1  sticky; set when the count would pass MAX_HOUR:59:59

Behaviour:
- Reset (async, rst=1): state IDLE; prescaler 0; count 00:00:00; lap snapshot 00:00:00; all outputs 0.
- States: IDLE (zero, stopped), RUN (counting), PAUSE (stopped, value held). All outputs are registered.
- IDLE: start_stop -> RUN with prescaler cleared to 0. lap_clear is ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1. On the cycle it equals TICKS_PER_SEC-1, it wraps to 0 and the count increments by 1 s. The new value is visible on the next edge.
  - First increment lands TICKS_PER_SEC cycles after the start pulse edge.
  - start_stop -> PAUSE.
  - lap_clear toggles lap_active. On 0->1, the snapshot register captures the current count, including any increment in that same cycle.
- PAUSE:
  - Prescaler and count are held, so no partial second is lost.
  - start_stop -> RUN and the prescaler resumes from its held value.
  - lap_clear -> IDLE: count, prescaler, snapshot, lap_active and overflow all cleared.
- Carry chain: seconds 59->00 carries to minutes; minutes 59->00 carries to hours. BCD digits never leave 0..9, and tens never exceed 5 for minutes and seconds. No binary division is used.
- Overflow: a tick at MAX_HOUR:59:59 leaves the count at MAX_HOUR:59:59, sets overflow, and moves to PAUSE. While overflow=1, start_stop is ignored; only lap_clear (in PAUSE) clears it.
- Display outputs show the snapshot when lap_active=1, otherwise the live count. lap_active persists across PAUSE/RUN transitions.
- Simultaneous start_stop and lap_clear in the same cycle: start_stop wins, lap_clear is dropped.
- Pulses wider than one cycle are not supported. Each high cycle counts as a separate event.
- An rst assertion mid-count aborts immediately to the reset state. There is no synchronous recovery dependency.

Decomposition:
- Shared package (timer_pkg): state encoding (IDLE=0, RUN=1, PAUSE=2), BCD constant for 59 (8'h59), and TICKS_PER_SEC default.
- Sub-module bcd_mod_counter #(MAX_BCD): a two-digit packed-BCD counter with inc, clr and hold inputs, and a carry output asserted on inc at MAX_BCD (wraps to 00). Instantiate three, with the hours instance using MAX_HOUR. Overflow detection uses the hours carry.
- Top level holds the FSM, prescaler, snapshot and output mux.

Test Plan:
All scenarios use TICKS_PER_SEC=4.
1. Reset, then start_stop pulse; run 4 cycles -> second_out_bcd=8'h01 on the 4th edge after the pulse. After 240 cycles -> 00:01:00, running=1.
2. Run to 00:00:02 plus 2 prescaler ticks, pause, wait 50 cycles, resume -> next increment to 00:00:03 exactly 2 cycles after resume; value is unchanged during the pause.
3. Lap: at 00:00:05 pulse lap_clear -> outputs hold 00:00:05, lap_active=1, while counting continues. Pulse again at live 00:00:09 -> outputs show 00:00:09, lap_active=0.
4. With MAX_HOUR=1, run to 01:59:59, then one more tick -> outputs stay 01:59:59, overflow=1, running=0. start_stop is ignored. lap_clear -> 00:00:00, overflow=0, IDLE.
5. Assert start_stop and lap_clear together in RUN -> PAUSE entered, lap_active unchanged. The same pair in PAUSE -> RUN, no clear.
6. Assert rst asynchronously mid-RUN at 00:12:34 (between edges) -> all outputs 0 immediately. After release, the first start_stop restarts from 00:00:00.
